// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding and default sizes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DEF_DBITS  = 16;
    localparam int          DEF_ABITS  = 12;
    localparam logic [15:0] DEF_ERRVAL = 16'hDEAD;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a CPU port (0) and a DMA port (1).
// Latency: request to ACK is two edges; a requester holds its request until ACK (no other backpressure).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int               DBITS  = DEF_DBITS,
    parameter int               ABITS  = DEF_ABITS,
    parameter logic [DBITS-1:0] ERRVAL = DBITS'(DEF_ERRVAL)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic             WE0,
    input  logic             WE1,
    input  logic [DBITS-1:0] ADDR0,
    input  logic [DBITS-1:0] ADDR1,
    input  logic [DBITS-1:0] WDATA0,
    input  logic [DBITS-1:0] WDATA1,
    output logic             ACK0,
    output logic             ACK1,
    output logic [DBITS-1:0] RDATA,
    output logic             ERR,
    output logic [ABITS-1:0] MADDR,
    output logic [DBITS-1:0] MDIN,
    output logic             MWE,
    input  logic [DBITS-1:0] MDOUT
);

    state_t           state;
    state_t           state_nxt;
    logic             grant;
    logic             win;
    logic             last_gnt;
    logic             lat_we;
    logic [DBITS-1:1] lat_addr;
    logic [DBITS-1:0] lat_wdata;
    logic [DBITS-1:0] rdata_q;
    logic             mapped;
    logic             unused_addr_lsb;

    // Byte-address bit 0 never reaches the word-addressed memory.
    assign unused_addr_lsb = ADDR0[0] ^ ADDR1[0];

    function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
            return ~last;
        end
        return r1;
    endfunction

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win       = last_gnt;
        case (state)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    state_nxt = BUSY;
                    grant     = 1'b1;
                    win       = rr_pick(REQ0, REQ1, last_gnt);
                end
            end
            BUSY: state_nxt = DONE;
            DONE: begin
                // Only the port that was not just served may chain straight into a new access.
                if (last_gnt ? REQ0 : REQ1) begin
                    state_nxt = BUSY;
                    grant     = 1'b1;
                    win       = ~last_gnt;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // last_gnt doubles as the in-flight port index while BUSY/DONE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_gnt  <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (grant) begin
                last_gnt  <= win;
                lat_we    <= win ? WE1 : WE0;
                lat_addr  <= win ? ADDR1[DBITS-1:1] : ADDR0[DBITS-1:1];
                lat_wdata <= win ? WDATA1 : WDATA0;
            end
            if (state == BUSY && !lat_we) begin
                rdata_q <= mapped ? MDOUT : ERRVAL;
            end
        end
    end

    assign mapped = (lat_addr[DBITS-1:ABITS+1] == '0);
    assign MADDR  = lat_addr[ABITS:1];
    assign MDIN   = lat_wdata;
    assign MWE    = (state == BUSY) && lat_we && mapped;
    assign ACK0   = (state == DONE) && !last_gnt;
    assign ACK1   = (state == DONE) && last_gnt;
    assign ERR    = (state == DONE) && !mapped;
    assign RDATA  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory behind it.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0, REQ1, WE0, WE1;
    logic [15:0] ADDR0, ADDR1, WDATA0, WDATA1;
    logic        ACK0, ACK1, ERR, MWE;
    logic [15:0] RDATA, MDIN, MDOUT;
    logic [11:0] MADDR;

    logic        ld_en = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] mem [4096];

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .ERR(ERR),
        .MADDR(MADDR), .MDIN(MDIN), .MWE(MWE), .MDOUT(MDOUT)
    );

    assign MDOUT = mem[MADDR];
    always @(posedge CLK) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (MWE) mem[MADDR] <= MDIN;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        @(negedge CLK);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge CLK);
        ld_en = 1'b0;
    endtask

    task automatic idle_inputs();
        REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    endtask

    task automatic reset_pulse();
        @(negedge CLK);
        RESET = 1'b1;
        idle_inputs();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_mwe;
        logic [11:0] exp_maddr;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          lat, mwe_cnt, nacks, bad_ack;
        logic        a0, a1, e;
        logic [15:0] rd, mw_data;
        logic [11:0] mw_addr;

        RESET = 1'b1;
        idle_inputs();
        #3;
        check("rst_ack0", ACK0, 0);
        check("rst_ack1", ACK1, 0);
        check("rst_err", ERR, 0);
        check("rst_mwe", MWE, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_state", 32'(dut.state), 32'(IDLE));

        preload(12'h100, 16'h1234);
        preload(12'hFFF, 16'hA5A5);
        preload(12'h002, 16'h2222);
        preload(12'h200, 16'h4444);
        preload(12'hFF9, 16'h0BAD);
        @(negedge CLK);
        RESET = 1'b0;

        //         port we  addr      wdata     rdata     err mwe maddr
        vecs[0] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'h1234, 1'b0, 0, 12'h000};
        vecs[1] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h1234, 1'b0, 1, 12'h008};
        vecs[2] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 0, 12'h000};
        vecs[3] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF, 1'b0, 0, 12'h000};
        vecs[4] = '{1'b0, 1'b0, 16'hFFF0, 16'h0000, 16'hDEAD, 1'b1, 0, 12'h000};
        vecs[5] = '{1'b0, 1'b1, 16'hFFF2, 16'h5555, 16'hDEAD, 1'b1, 0, 12'h000};
        vecs[6] = '{1'b1, 1'b0, 16'h1FFE, 16'h0000, 16'hA5A5, 1'b0, 0, 12'h000};
        vecs[7] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 16'hDEAD, 1'b1, 0, 12'h000};
        vecs[8] = '{1'b0, 1'b1, 16'h1FFE, 16'h7777, 16'hDEAD, 1'b0, 1, 12'hFFF};
        vecs[9] = '{1'b1, 1'b0, 16'h1FFE, 16'h0000, 16'h7777, 1'b0, 0, 12'h000};

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (vecs[i].port) begin
                REQ1 = 1; WE1 = vecs[i].we; ADDR1 = vecs[i].addr; WDATA1 = vecs[i].wdata;
            end else begin
                REQ0 = 1; WE0 = vecs[i].we; ADDR0 = vecs[i].addr; WDATA0 = vecs[i].wdata;
            end
            lat = 99; mwe_cnt = 0; mw_addr = '0; mw_data = '0;
            a0 = 0; a1 = 0; e = 0; rd = '0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge CLK);
                if (MWE) begin
                    mwe_cnt++; mw_addr = MADDR; mw_data = MDIN;
                end
                if (ACK0 || ACK1) begin
                    lat = c; a0 = ACK0; a1 = ACK1; e = ERR; rd = RDATA;
                    break;
                end
            end
            idle_inputs();
            check($sformatf("v%0d_latency", i), lat, 2);
            check($sformatf("v%0d_ack0", i), a0, !vecs[i].port);
            check($sformatf("v%0d_ack1", i), a1, vecs[i].port);
            check($sformatf("v%0d_err", i), e, vecs[i].exp_err);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_mwe_cycles", i), mwe_cnt, vecs[i].exp_mwe);
            if (vecs[i].exp_mwe != 0) begin
                check($sformatf("v%0d_maddr", i), mw_addr, vecs[i].exp_maddr);
                check($sformatf("v%0d_mdin", i), mw_data, vecs[i].wdata);
            end
            @(negedge CLK);
        end
        check("unmapped_write_mem", mem[12'hFF9], 16'h0BAD);

        // Sustained contention straight after reset: port 0 wins the first tie, then alternation.
        reset_pulse();
        REQ0 = 1; ADDR0 = 16'h0200;
        REQ1 = 1; ADDR1 = 16'h0010;
        nacks = 0; bad_ack = 0;
        for (int c = 1; c <= 14 && nacks < 4; c++) begin
            @(negedge CLK);
            if (ACK0 && ACK1) bad_ack++;
            if (ACK0 || ACK1) begin
                check($sformatf("rr%0d_port", nacks), ACK1, nacks % 2);
                check($sformatf("rr%0d_cycle", nacks), c, 2 + 2 * nacks);
                check($sformatf("rr%0d_rdata", nacks), RDATA, (nacks % 2) ? 16'hBEEF : 16'h1234);
                nacks++;
                if (nacks == 4) idle_inputs();
            end
        end
        idle_inputs();
        check("rr_ack_count", nacks, 4);
        check("rr_ack_onehot", bad_ack, 0);
        @(negedge CLK);

        // Requester changes its inputs while BUSY; the latched access must be unaffected.
        @(negedge CLK);
        REQ0 = 1; WE0 = 0; ADDR0 = 16'h0200;
        @(negedge CLK);
        ADDR0 = 16'h0400; WE0 = 1; WDATA0 = 16'hFFFF;
        #1;
        check("chg_maddr", MADDR, 12'h100);
        check("chg_mwe", MWE, 0);
        @(negedge CLK);
        check("chg_ack0", ACK0, 1);
        check("chg_rdata", RDATA, 16'h1234);
        idle_inputs();
        @(negedge CLK);
        check("chg_mem200", mem[12'h200], 16'h4444);

        // Reset pulsed in the middle of a write access.
        @(negedge CLK);
        REQ0 = 1; WE0 = 1; ADDR0 = 16'h0004; WDATA0 = 16'h9999;
        @(posedge CLK);
        #2;
        check("rstbusy_mwe_before", MWE, 1);
        check("rstbusy_maddr", MADDR, 12'h002);
        RESET = 1'b1;
        #1;
        check("rstbusy_mwe_after", MWE, 0);
        check("rstbusy_state", 32'(dut.state), 32'(IDLE));
        @(negedge CLK);
        idle_inputs();
        @(negedge CLK);
        RESET = 1'b0;
        bad_ack = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (ACK0 || ACK1 || MWE) bad_ack++;
        end
        check("rstbusy_no_ack", bad_ack, 0);
        check("rstbusy_mem2", mem[12'h002], 16'h2222);
        check("rstbusy_rdata", RDATA, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
